// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter sharing one single-port nibble RAM through a 4-phase access FSM.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port A has fixed priority.
module ram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t            r_state, w_next;
    logic              r_we, r_win_b;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_a_rdata, r_b_rdata;
    logic              w_any, w_pick_b, w_grant, w_drive;

    assign w_any   = a_req | b_req;
    assign w_grant = (r_state == IDLE) && w_any;

`ifdef ARB_ROUND_ROBIN_EN
    // r_prio_b set means B is next on contention
    logic r_prio_b;
    assign w_pick_b = b_req & (~a_req | r_prio_b);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_prio_b <= 1'b0;
        else if (w_grant)
            r_prio_b <= ~w_pick_b;
`else
    assign w_pick_b = b_req & ~a_req;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;

    always_comb begin
        w_next  = r_state;
        ram_cs  = 1'b0;
        ram_we  = 1'b0;
        w_drive = 1'b0;
        a_ack   = 1'b0;
        b_ack   = 1'b0;
        case (r_state)
            IDLE:    w_next = w_any ? SETUP : IDLE;
            SETUP: begin
                ram_cs = 1'b1;
                w_next = ACCESS;
            end
            ACCESS: begin
                ram_cs  = 1'b1;
                ram_we  = r_we;
                w_drive = r_we;
                w_next  = DONE;
            end
            DONE: begin
                a_ack  = ~r_win_b;
                b_ack  = r_win_b;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_win_b   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_win_b <= w_pick_b;
                r_we    <= w_pick_b ? b_we : a_we;
                r_addr  <= w_pick_b ? b_addr : a_addr;
                r_wdata <= w_pick_b ? b_wdata : a_wdata;
            end
            // read data is captured on the edge that leaves ACCESS
            if (r_state == ACCESS && !r_we) begin
                if (r_win_b)
                    r_b_rdata <= ram_data;
                else
                    r_a_rdata <= ram_data;
            end
        end

    assign ram_addr = r_addr;
    assign ram_data = w_drive ? r_wdata : {DATA_W{1'bz}};
    assign a_rdata  = r_a_rdata;
    assign b_rdata  = r_b_rdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with an ack-driven scoreboard and a RAM bus model.
module tb_ram_arbiter;
    logic        clk = 0, rst_n = 0;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [11:0] a_addr = 0, b_addr = 0;
    logic [3:0]  a_wdata = 0, b_wdata = 0;
    logic        a_ack, b_ack, ram_cs, ram_we;
    logic [3:0]  a_rdata, b_rdata;
    logic [11:0] ram_addr;
    wire  [3:0]  ram_data;
    logic [3:0]  mem [4096];
    int          checks = 0, errors = 0;

    typedef struct packed {logic p; logic [3:0] ar; logic [3:0] br;} exp_t;
    exp_t sb[$];

    logic        pcs = 0, pwe = 0;
    logic [11:0] paddr = 0;

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data)
    );

    assign ram_data = (ram_cs && !ram_we) ? mem[ram_addr] : 4'bz;
    always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic p, input logic [3:0] ar, input logic [3:0] br);
        sb.push_back({p, ar, br});
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_ack || b_ack) begin
                if (sb.size() == 0)
                    chk("unexpected_ack", {30'd0, b_ack, a_ack}, 0);
                else begin
                    chk("ack_port", {30'd0, b_ack, a_ack}, sb[0].p ? 2 : 1);
                    chk("a_rdata", a_rdata, sb[0].ar);
                    chk("b_rdata", b_rdata, sb[0].br);
                    void'(sb.pop_front());
                end
            end
            if (ram_we) begin
                chk("we_after_setup", {pcs, pwe}, 2'b10);
                chk("we_addr_stable", ram_addr, paddr);
                chk("wdata_bus", ram_data, (a_req && a_we) ? a_wdata : b_wdata);
            end
        end
        pcs   <= ram_cs;
        pwe   <= ram_we;
        paddr <= ram_addr;
    end

    task automatic run_port(input bit p, input int n, input bit we, input logic [11:0] addr,
                            input logic [3:0] wd, input bit lat);
        int cyc;
        if (p) begin b_we = we; b_addr = addr; b_wdata = wd; b_req = 1; end
        else   begin a_we = we; a_addr = addr; a_wdata = wd; a_req = 1; end
        for (int k = 0; k < n; k++) begin
            cyc = 0;
            do begin @(posedge clk); #1; cyc++; end while (!(p ? b_ack : a_ack) && cyc < 30);
            chk(p ? "b_ack_seen" : "a_ack_seen", p ? b_ack : a_ack, 1);
            if (lat) chk("latency", cyc, 3);
        end
        @(posedge clk); #1;
        if (p) b_req = 0; else a_req = 0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 4'(i * 7 + 3);
        mem[0] = 4'h9; mem[1] = 4'h3; mem[2] = 4'h1; mem[16] = 4'hA; mem[32] = 4'h5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", ram_cs, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_ack", {a_ack, b_ack}, 0);
        chk("rst_rdata", {a_rdata, b_rdata}, 0);
        rst_n = 1;

        push(0, 4'h0, 4'h0); run_port(0, 1, 1, 12'h001, 4'hC, 1);
        push(0, 4'hC, 4'h0); run_port(0, 1, 0, 12'h001, 4'h0, 1);
        push(1, 4'hC, 4'h0); run_port(1, 1, 1, 12'h002, 4'h6, 1);
        push(0, 4'h6, 4'h0); run_port(0, 1, 0, 12'h002, 4'h0, 1);
        push(1, 4'h6, 4'hC); run_port(1, 1, 0, 12'h001, 4'h0, 1);

`ifdef ARB_ROUND_ROBIN_EN
        push(0, 4'hA, 4'hC); push(1, 4'hA, 4'h5); push(0, 4'hA, 4'h5); push(1, 4'hA, 4'h5);
`else
        push(0, 4'hA, 4'hC); push(0, 4'hA, 4'hC); push(1, 4'hA, 4'h5); push(1, 4'hA, 4'h5);
`endif
        fork
            run_port(0, 2, 0, 12'h010, 4'h0, 0);
            run_port(1, 2, 0, 12'h020, 4'h0, 0);
        join

        push(0, 4'h6, 4'h5); run_port(0, 1, 0, 12'h002, 4'h0, 1);

`ifdef ARB_ROUND_ROBIN_EN
        push(1, 4'h6, 4'hA); push(0, 4'hC, 4'hA);
`else
        push(0, 4'hC, 4'h5); push(1, 4'hC, 4'hA);
`endif
        fork
            run_port(0, 1, 0, 12'h001, 4'h0, 0);
            run_port(1, 1, 0, 12'h010, 4'h0, 0);
        join

        push(0, 4'hA, 4'hA); push(1, 4'hA, 4'h5);
        fork
            run_port(0, 1, 0, 12'h010, 4'h0, 1);
            begin @(posedge clk); #1; run_port(1, 1, 0, 12'h020, 4'h0, 0); end
        join

        a_we = 1; a_addr = 12'h004; a_wdata = 4'h7; a_req = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("in_access_we", ram_we, 1);
        #2 rst_n = 0;
        #1;
        chk("abort_cs", ram_cs, 0);
        chk("abort_we", ram_we, 0);
        chk("abort_addr", ram_addr, 0);
        chk("abort_ack", {a_ack, b_ack}, 0);
        chk("abort_rdata", {a_rdata, b_rdata}, 0);
        a_req = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("no_ack_in_reset", a_ack, 0);
        rst_n = 1;

        push(0, 4'h9, 4'h0); push(1, 4'h9, 4'h6);
        fork
            run_port(0, 1, 0, 12'h000, 4'h0, 1);
            run_port(1, 1, 0, 12'h002, 4'h0, 0);
        join

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
